// File: rtl/cell_locator_pkg.sv
// Shared board-index definitions. Used by cell_locator and by the draw stages
// that consume cell indices.
package cell_locator_pkg;
  localparam int IND_W = 5;
  localparam int POS_W = 12;
  localparam int PIT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIV,
    DONE
  } cl_state_t;
endpackage

// File: rtl/cell_axis_div.sv
// Per-axis bounded repeated-subtraction divider: quotient saturates at limit_i.
// done_o is combinational on the current remainder/count.
module cell_axis_div
  import cell_locator_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [POS_W-1:0] rem_i,
  input  logic [PIT_W-1:0] pitch_i,
  input  logic [IND_W-1:0] limit_i,
  input  logic             step_i,
  output logic             done_o,
  output logic [IND_W-1:0] quot_o
);
  logic [POS_W-1:0] rem_q, rem_d;
  logic [IND_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pitch_w;

  assign pitch_w = {{(POS_W-PIT_W){1'b0}}, pitch_i};
  // rem only shrinks when it covers a whole pitch, so it never underflows
  assign done_o  = (rem_q < pitch_w) || (cnt_q == limit_i);
  assign quot_o  = cnt_q;

  always_comb begin
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (load_i) begin
      rem_d = rem_i;
      cnt_d = '0;
    end else if (step_i && !done_o) begin
      rem_d = rem_q - pitch_w;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cell_locator.sv
// Pixel-to-cell decoder: maps a pointer position to 1-based board cell indices
// using two bounded subtractors under a start/valid FSM.
module cell_locator
  import cell_locator_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [11:0]      mouse_xpos,
  input  logic [11:0]      mouse_ypos,
  input  logic [10:0]      board_xpos,
  input  logic [10:0]      board_ypos,
  input  logic [6:0]       button_size,
  input  logic [4:0]       board_size,
  input  logic [1:0]       level,
  output logic             busy,
  output logic             valid,
  output logic             hit,
  output logic [IND_W-1:0] cell_ind_x,
  output logic [IND_W-1:0] cell_ind_y
);
  cl_state_t        state_q;
  logic [11:0]      mx_q, my_q;
  logic [10:0]      bx_q, by_q;
  logic [6:0]       bsz_q;
  logic [4:0]       nsz_q;
  logic [1:0]       lvl_q;
  logic             busy_q, valid_q, hit_q;
  logic [IND_W-1:0] ind_x_q, ind_y_q;

  logic             miss, load, step;
  logic             done_x, done_y;
  logic [IND_W-1:0] q_x, q_y;
  logic [POS_W-1:0] dx, dy;
  logic             div_hit;

  assign miss = (mx_q < {1'b0, bx_q}) || (my_q < {1'b0, by_q}) ||
                (lvl_q == 2'd0) || (bsz_q == 7'd0);
  assign dx   = mx_q - {1'b0, bx_q};
  assign dy   = my_q - {1'b0, by_q};
  assign load = (state_q == CHECK) && !miss;
  assign step = (state_q == DIV);
  // a quotient that reached board_size means the pointer is past the last cell
  assign div_hit = (q_x < nsz_q) && (q_y < nsz_q);

  // horizontal pitch includes the one-pixel gap between buttons
  cell_axis_div u_div_x (
    .clk(clk), .rst(rst), .load_i(load), .rem_i(dx),
    .pitch_i({1'b0, bsz_q} + 8'd1), .limit_i(nsz_q), .step_i(step),
    .done_o(done_x), .quot_o(q_x)
  );

  cell_axis_div u_div_y (
    .clk(clk), .rst(rst), .load_i(load), .rem_i(dy),
    .pitch_i({1'b0, bsz_q}), .limit_i(nsz_q), .step_i(step),
    .done_o(done_y), .quot_o(q_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      ind_x_q <= '0;
      ind_y_q <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      bsz_q   <= '0;
      nsz_q   <= '0;
      lvl_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          mx_q    <= mouse_xpos;
          my_q    <= mouse_ypos;
          bx_q    <= board_xpos;
          by_q    <= board_ypos;
          bsz_q   <= button_size;
          nsz_q   <= board_size;
          lvl_q   <= level;
          busy_q  <= 1'b1;
          state_q <= CHECK;
        end
        CHECK: if (miss) begin
          hit_q   <= 1'b0;
          ind_x_q <= '0;
          ind_y_q <= '0;
          valid_q <= 1'b1;
          state_q <= DONE;
        end else begin
          state_q <= DIV;
        end
        DIV: if (done_x && done_y) begin
          hit_q   <= div_hit;
          ind_x_q <= div_hit ? q_x + 1'b1 : '0;
          ind_y_q <= div_hit ? q_y + 1'b1 : '0;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign hit        = hit_q;
  assign cell_ind_x = ind_x_q;
  assign cell_ind_y = ind_y_q;
endmodule

// File: tb/tb_cell_locator.sv
// Directed bench for cell_locator: latency, hit/miss, index values, start
// re-pulse and mid-operation reset.
module tb_cell_locator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
  logic [10:0] board_xpos = 11'd100, board_ypos = 11'd50;
  logic [6:0]  button_size = 7'd30;
  logic [4:0]  board_size = 5'd8;
  logic [1:0]  level = 2'd1;
  logic        busy, valid, hit;
  logic [4:0]  cell_ind_x, cell_ind_y;

  int n_chk = 0, n_pass = 0;

  cell_locator dut (
    .clk(clk), .rst(rst), .start(start),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .board_xpos(board_xpos), .board_ypos(board_ypos),
    .button_size(button_size), .board_size(board_size), .level(level),
    .busy(busy), .valid(valid), .hit(hit),
    .cell_ind_x(cell_ind_x), .cell_ind_y(cell_ind_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Start a request in cycle 0; inputs are scrambled after cycle 0 to
  // confirm the block works on latched copies.
  task automatic run(input string tag, input int mx, input int my,
                     input int exp_cyc, input int exp_hit,
                     input int ex, input int ey);
    int cyc;
    mouse_xpos = 12'(mx);
    mouse_ypos = 12'(my);
    start = 1'b1;
    tick();
    start = 1'b0;
    mouse_xpos = 12'd4000;
    mouse_ypos = 12'd7;
    cyc = 1;
    chk({tag, "_busy_c1"}, int'(busy), 1);
    while (!valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_cyc);
    chk({tag, "_busy_done"}, int'(busy), 1);
    chk({tag, "_hit"}, int'(hit), exp_hit);
    chk({tag, "_ix"}, int'(cell_ind_x), ex);
    chk({tag, "_iy"}, int'(cell_ind_y), ey);
    tick();
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_valid_1cyc"}, int'(valid), 0);
    chk({tag, "_hit_hold"}, int'(hit), exp_hit);
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_ix", int'(cell_ind_x), 0);
    chk("rst_iy", int'(cell_ind_y), 0);
    tick();

    run("origin", 100, 50, 3, 1, 1, 1);
    run("mid", 162, 110, 5, 1, 3, 3);
    run("lastcol", 347, 60, 10, 1, 8, 1);
    run("pastcol", 348, 60, 11, 0, 0, 0);
    run("left", 99, 60, 2, 0, 0, 0);
    level = 2'd0;
    run("nolevel", 150, 80, 2, 0, 0, 0);
    level = 2'd1;
    run("up", 130, 49, 2, 0, 0, 0);

    // start re-pulsed in cycles 1-4 with a different pointer
    mouse_xpos = 12'd162; mouse_ypos = 12'd110;
    start = 1'b1;
    tick();
    mouse_xpos = 12'd348; mouse_ypos = 12'd60;
    nv = 0;
    for (int c = 1; c <= 4; c++) begin
      if (valid) nv++;
      tick();
    end
    start = 1'b0;
    // now in cycle 5 (DONE)
    chk("rep_hit", int'(hit), 1);
    chk("rep_ix", int'(cell_ind_x), 3);
    chk("rep_iy", int'(cell_ind_y), 3);
    for (int c = 5; c <= 20; c++) begin
      if (valid) nv++;
      if (c == 6) chk("rep_busy_c6", int'(busy), 0);
      tick();
    end
    chk("rep_nvalid", nv, 1);

    // reset during DIV
    mouse_xpos = 12'd348; mouse_ypos = 12'd60;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_hit", int'(hit), 0);
    chk("abort_ix", int'(cell_ind_x), 0);
    chk("abort_iy", int'(cell_ind_y), 0);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 15; c++) begin
      if (valid) nv++;
      tick();
    end
    chk("abort_novalid", nv, 0);
    run("after_rst", 130, 80, 4, 1, 1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cell_locator.md
# cell_locator

Pixel-to-cell decoder for the Saper board: converts a pointer position in screen pixels into 1-based cell indices (ind_x, ind_y), using the same board origin, button size and pitch that the draw stages use. Sits between the mouse position path and the game-control logic and drives the mine/flag/reveal index inputs. It is a bounded repeated-subtraction divider under a small FSM with a start/valid handshake; no multipliers.

## Interface
- No parameters; widths fixed to the board datapath.
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- mouse_xpos  in  12  pointer x, pixels
- mouse_ypos  in  12  pointer y, pixels
- board_xpos  in  11  board left edge, pixels
- board_ypos  in  11  board top edge, pixels
- button_size  in  7  cell size, pixels
- board_size  in  5  cells per side (1..31)
- level  in  2  game level; 0 means no game, so every lookup misses
- busy  out  1  high from CHECK through DONE
- valid  out  1  one-cycle result strobe
- hit  out  1  pointer lies on a cell; qualified by valid, held afterwards
- cell_ind_x  out  5  1-based column index; 0 on a miss
- cell_ind_y  out  5  1-based row index; 0 on a miss

## Operation
- States: IDLE, CHECK, DIV, DONE.
- IDLE with start=1: latch all inputs, go to CHECK. start in any other state is ignored and not queued.
- CHECK: miss if any of the following hold: mouse_xpos < board_xpos, mouse_ypos < board_ypos, level==0, button_size==0. On a miss go to DONE with hit=0. Otherwise load rem_x=mouse_xpos-board_xpos, rem_y=mouse_ypos-board_ypos, cnt_x=cnt_y=0, then go to DIV.
- Pitch: pitch_x = button_size+1 (8 bits), pitch_y = button_size.
- DIV: the two axes run in parallel. Each cycle, each axis with rem>=pitch and cnt<board_size does rem-=pitch and cnt+=1. An axis is done when rem<pitch or cnt==board_size. Leave for DONE on the edge where both axes are done.
- Result registered on entry to DONE:
  - hit = (cnt_x<board_size && cnt_y<board_size)
  - cell_ind_x = hit ? cnt_x+1 : 0; cell_ind_y = hit ? cnt_y+1 : 0
- DONE: valid=1 for exactly one cycle, then go to IDLE. hit and cell_ind_x/cell_ind_y hold until the next DONE.
- Input changes after start are invisible to the block because the latched copies are used.
- Width rules: rem is 12 bits unsigned, cnt is 5 bits. Subtraction happens only when rem>=pitch, so there is no underflow. cnt never exceeds board_size.

## Timing
- Cycle 0: start high in IDLE. Cycle 1: CHECK, busy=1.
- Miss in CHECK: DONE and valid in cycle 2.
- Hit path: DIV occupies max(q_x,q_y)+1 cycles, where q is the final cnt per axis. valid appears in cycle max(q_x,q_y)+3.
- Worst case is board_size+3 cycles after start; latency is always bounded.
- busy falls in the cycle after DONE. A new start is accepted in that cycle at the earliest.
- Reset values: state IDLE, busy=0, valid=0, hit=0, cell_ind_x=0, cell_ind_y=0.
- rst in any state aborts the operation on the next edge with no valid strobe. Outputs take their reset values.

## Structure
- Shared game package holds the state enum (cl_state_t) and the index width constant (IND_W=5). It is shared with the draw stages that consume indices.
- Natural sub-module: cell_axis_div, the per-axis bounded subtractor. Ports: rem/cnt load, pitch, limit, step enable, done, quotient.
  - Instantiated twice, for x and y; the FSM sits in cell_locator.

## Test plan
Common setup: board_xpos=100, board_ypos=50, button_size=30, board_size=8, level=1.
- mouse (100,50), start -> valid in cycle 3: hit=1, ind (1,1).
- mouse (162,110) -> dx=62, dy=60, q=(2,2) -> valid in cycle 5: hit=1, ind (3,3).
- mouse (347,60) -> dx=247, q_x=7, rem 30<31 -> valid in cycle 10: hit=1, ind (8,1). mouse (348,60) -> q_x reaches 8 -> valid in cycle 11: hit=0, ind (0,0).
- mouse (99,60) -> valid in cycle 2, hit=0. Repeat with level=0 and mouse (150,80) -> valid in cycle 2, hit=0.
- start re-pulsed in cycles 1-4 of an operation -> exactly one valid. Results match the first request; busy low in the cycle after DONE.
- rst asserted in DIV -> next cycle all outputs 0, no valid. Then start with mouse (130,80) -> valid with hit=1, ind (1,2).
